uart_ctrl: RTL and testbench
============================

UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, SHALL set entries per TX and RX FIFO; power of two, 2..64.
REQ-002 Parameter STATUS_ADDR, default 1'b1, SHALL set the bus_addr value selecting the status register; the other value selects the data register.
REQ-003 clk  in  1  sole clock; every flop on posedge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 bus_req  in  1  one-cycle access request.
REQ-006 bus_we  in  1  1=write, 0=read; qualified by bus_req.
REQ-007 bus_addr  in  1  register select.
REQ-008 bus_wdata  in  8  write data.
REQ-009 bus_ack  out  1  one-cycle completion pulse.
REQ-010 bus_rdata  out  8  read data, valid while bus_ack=1, else 0x00.
REQ-011 tx_start  out  1  start pulse to async_transmitter.
REQ-012 tx_data  out  8  byte to async_transmitter, held from tx_start until tx_busy falls.
REQ-013 tx_busy  in  1  transmitter busy.
REQ-014 rx_ready  in  1  async_receiver data-ready.
REQ-015 rx_data  in  8  async_receiver byte.
REQ-016 rx_clear  out  1  clear pulse to async_receiver.

Function
REQ-017 Every bus_req SHALL produce bus_ack exactly 1 cycle later; no back-pressure; requests may arrive every cycle.
REQ-018 Data write SHALL push bus_wdata into TX FIFO if not full; if full, SHALL drop the byte and set sticky tx_ovf.
REQ-019 Data read SHALL return RX FIFO head and pop it; if RX FIFO empty, SHALL return 0x00 with no pop.
REQ-020 Status read SHALL return {0, tx_idle, tx_not_full, 0, 0, tx_ovf, rx_ovf, rx_nonempty} (bit7..bit0), sampled at request cycle, then clear rx_ovf and tx_ovf; status writes SHALL be ignored but acked.
REQ-021 tx_idle SHALL be 1 iff TX FIFO empty, TX FSM in T_IDLE and tx_busy=0.
REQ-022 TX FSM states T_IDLE, T_START, T_WAITHI, T_WAITLO; T_IDLE->T_START when FIFO nonempty and tx_busy=0, popping head into tx_data.
REQ-023 T_START SHALL drive tx_start=1 for exactly one cycle, then go to T_WAITHI.
REQ-024 T_WAITHI SHALL go to T_WAITLO when tx_busy=1; T_WAITLO SHALL go to T_IDLE when tx_busy=0; one byte per transmitter frame, no byte lost or duplicated.
REQ-025 RX FSM states R_IDLE, R_CLEAR, R_WAITLO; R_IDLE on rx_ready=1 SHALL capture rx_data into RX FIFO (or set rx_ovf and discard if full) and go to R_CLEAR.
REQ-026 R_CLEAR SHALL drive rx_clear=1 one cycle, then R_WAITLO; R_WAITLO SHALL return to R_IDLE when rx_ready=0; each received byte captured exactly once.
REQ-027 FIFO push and pop in the same cycle SHALL both occur; when full, a same-cycle pop SHALL free space so the push is accepted; when empty, a same-cycle push SHALL NOT be popped that cycle.
REQ-028 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrapping modulo 2*FIFO_DEPTH; full/empty from pointer MSB compare.
REQ-029 Status read and rx_ovf set in the same cycle: rx_ovf SHALL end set (set wins); same for tx_ovf.

Reset
REQ-030 With rst_n=0 at a posedge: both FIFOs empty, both FSMs idle, tx_ovf=rx_ovf=0, bus_ack=0, bus_rdata=0x00, tx_start=0, rx_clear=0, tx_data=0x00.
REQ-031 Reset mid-frame SHALL NOT abort the transmitter; after release TX FSM SHALL wait for tx_busy=0 (T_IDLE rule) before issuing tx_start.
REQ-032 Bus requests during reset SHALL be ignored, with no ack.

Verification
REQ-033 Write 0x41,0x42,0x43 to data reg back-to-back -> three bus_ack pulses; transmitter serializes 0x41,0x42,0x43 in order; tx_idle=1 afterwards.
REQ-034 Write 9 bytes with transmitter held busy (FIFO_DEPTH=8) -> 8 sent, 9th dropped; status read returns bit2=1, next status read bit2=0.
REQ-035 Receiver delivers 0x55 -> one rx_clear pulse; status bit0=1; data read returns 0x55; next data read returns 0x00, bit0=0.
REQ-036 Receiver delivers 9 bytes unread -> first 8 readable in order, rx_ovf=1; rx_ready asserted and status read same cycle -> rx_ovf remains 1.
REQ-037 Assert rst_n=0 during transmission of 0x7E with 3 queued -> FIFO empty, no further tx_start until tx_busy=0, then only newly written bytes sent.

Source files
------------

// File: rtl/uart_ctrl.sv
// -----------------------------------------------------------------------------
// uart_ctrl
//   Bus-side register front end for a byte UART. A TX FIFO is filled by writes
//   to the data register and handed one byte per frame to an external
//   async_transmitter. Bytes from an external async_receiver are captured into
//   an RX FIFO and returned by reads of the data register. The status register
//   reports FIFO state and sticky overflow flags, which are cleared when the
//   status register is read.
//
//   Ports
//     clk        sole clock, every flop on posedge
//     rst_n      synchronous active-low reset
//     bus_req    one-cycle access request
//     bus_we     1 = write, 0 = read (qualified by bus_req)
//     bus_addr   register select (STATUS_ADDR = status, other = data)
//     bus_wdata  write data
//     bus_ack    completion pulse, exactly one cycle after bus_req
//     bus_rdata  read data while bus_ack = 1, else 0x00
//     tx_start   start pulse to the transmitter
//     tx_data    byte to the transmitter, held for the whole frame
//     tx_busy    transmitter busy
//     rx_ready   receiver data-ready
//     rx_data    received byte
//     rx_clear   clear pulse to the receiver
//
//   Status register bits (7..0):
//     {0, tx_idle, tx_not_full, 0, 0, tx_ovf, rx_ovf, rx_nonempty}
// -----------------------------------------------------------------------------

// Synchronous FIFO used for both directions. The FIFO decides internally
// whether a requested push/pop actually happens: a pop on an empty FIFO is
// ignored, and a push into a full FIFO is accepted only when a pop frees an
// entry in the same cycle.
module uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_wdata,
  input  logic       i_pop,
  output logic [7:0] o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the index bits
  // match; pointers wrap modulo 2*DEPTH.
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: the storage array has no reset; only the pointers define which
  // entries are valid, and leaving the array unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

module uart_ctrl #(
  parameter int   FIFO_DEPTH  = 8,
  parameter logic STATUS_ADDR = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bus_req,
  input  logic       bus_we,
  input  logic       bus_addr,
  input  logic [7:0] bus_wdata,
  output logic       bus_ack,
  output logic [7:0] bus_rdata,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       rx_clear
);

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_START  = 2'd1;
  localparam logic [1:0] T_WAITHI = 2'd2;
  localparam logic [1:0] T_WAITLO = 2'd3;

  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_CLEAR  = 2'd1;
  localparam logic [1:0] R_WAITLO = 2'd2;

  logic [1:0] r_tx_state;
  logic [1:0] r_rx_state;
  logic [7:0] r_tx_data;
  logic       r_bus_ack;
  logic [7:0] r_bus_rdata;
  logic       r_tx_ovf;
  logic       r_rx_ovf;

  logic       w_wr_data;
  logic       w_rd_data;
  logic       w_rd_stat;
  logic       w_tx_pop;
  logic       w_tx_full;
  logic       w_tx_empty;
  logic [7:0] w_tx_head;
  logic       w_tx_drop;
  logic       w_tx_idle;
  logic       w_rx_push;
  logic       w_rx_full;
  logic       w_rx_empty;
  logic [7:0] w_rx_head;
  logic       w_rx_drop;
  logic [7:0] w_status;

  // Bus decode. Status writes decode to nothing and are only acknowledged.
  assign w_wr_data = bus_req &  bus_we & (bus_addr != STATUS_ADDR);
  assign w_rd_data = bus_req & ~bus_we & (bus_addr != STATUS_ADDR);
  assign w_rd_stat = bus_req & ~bus_we & (bus_addr == STATUS_ADDR);

  // A byte leaves the TX FIFO only when the transmitter is free, so a frame
  // still running across a reset is never overlapped by a new start.
  assign w_tx_pop  = (r_tx_state == T_IDLE) & ~w_tx_empty & ~tx_busy;
  assign w_rx_push = (r_rx_state == R_IDLE) & rx_ready;

  // Drops happen only when full and no same-cycle pop frees an entry.
  assign w_tx_drop = w_wr_data & w_tx_full & ~w_tx_pop;
  assign w_rx_drop = w_rx_push & w_rx_full & ~w_rd_data;

  assign w_tx_idle = w_tx_empty & (r_tx_state == T_IDLE) & ~tx_busy;
  assign w_status  = {1'b0, w_tx_idle, ~w_tx_full, 2'b00,
                      r_tx_ovf, r_rx_ovf, ~w_rx_empty};

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_wr_data),
    .i_wdata (bus_wdata),
    .i_pop   (w_tx_pop),
    .o_head  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rx_push),
    .i_wdata (rx_data),
    .i_pop   (w_rd_data),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  // Bus response and sticky overflow flags. A new overflow in the same cycle
  // as a status read leaves the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bus_ack   <= 1'b0;
      r_bus_rdata <= 8'h00;
      r_tx_ovf    <= 1'b0;
      r_rx_ovf    <= 1'b0;
    end else begin
      r_bus_ack <= bus_req;
      if (w_rd_stat)
        r_bus_rdata <= w_status;
      else if (w_rd_data && !w_rx_empty)
        r_bus_rdata <= w_rx_head;
      else
        r_bus_rdata <= 8'h00;

      if (w_tx_drop)      r_tx_ovf <= 1'b1;
      else if (w_rd_stat) r_tx_ovf <= 1'b0;

      if (w_rx_drop)      r_rx_ovf <= 1'b1;
      else if (w_rd_stat) r_rx_ovf <= 1'b0;
    end
  end

  // TX handshake: load byte, pulse start, then follow one full busy frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state <= T_IDLE;
      r_tx_data  <= 8'h00;
    end else begin
      case (r_tx_state)
        T_IDLE: begin
          if (w_tx_pop) begin
            r_tx_data  <= w_tx_head;
            r_tx_state <= T_START;
          end
        end
        T_START:  r_tx_state <= T_WAITHI;
        T_WAITHI: if (tx_busy)  r_tx_state <= T_WAITLO;
        T_WAITLO: if (!tx_busy) r_tx_state <= T_IDLE;
        default:  r_tx_state <= T_IDLE;
      endcase
    end
  end

  // RX handshake: capture once on rx_ready, pulse clear, then wait for the
  // receiver to drop rx_ready so the same byte is never captured twice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_state <= R_IDLE;
    end else begin
      case (r_rx_state)
        R_IDLE:   if (rx_ready)  r_rx_state <= R_CLEAR;
        R_CLEAR:  r_rx_state <= R_WAITLO;
        R_WAITLO: if (!rx_ready) r_rx_state <= R_IDLE;
        default:  r_rx_state <= R_IDLE;
      endcase
    end
  end

  assign bus_ack   = r_bus_ack;
  assign bus_rdata = r_bus_rdata;
  assign tx_start  = (r_tx_state == T_START);
  assign tx_data   = r_tx_data;
  assign rx_clear  = (r_rx_state == R_CLEAR);

endmodule

// File: tb/tb_uart_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_ctrl
//   Self-checking bench for uart_ctrl. Expected bus read data is queued when a
//   request is driven and compared when bus_ack arrives; expected transmitted
//   bytes are queued when written and compared at each tx_start by a simple
//   transmitter model. A receiver model delivers bytes through the
//   rx_ready/rx_clear handshake.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_ctrl;

  localparam logic A_STAT = 1'b1;
  localparam logic A_DATA = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bus_req;
  logic       bus_we;
  logic       bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_ack;
  logic [7:0] bus_rdata;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_clear;

  typedef struct {
    bit         chk;
    logic [7:0] val;
  } bus_exp_t;

  bus_exp_t   exp_bus[$];
  logic [8:0] exp_tx[$];

  int n_checks = 0;
  int n_err    = 0;
  int n_start  = 0;
  int n_clr    = 0;
  bit hold_busy  = 1'b0;
  bit busy_force = 1'b0;

  uart_ctrl #(.FIFO_DEPTH(8), .STATUS_ADDR(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_clear  (rx_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- bus helpers (drive at negedge) ----------------
  task automatic bus_drive(input logic addr, input logic we, input logic [7:0] wdata,
                           input bit chk, input logic [7:0] exp);
    bus_exp_t e;
    bus_req   = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    e.chk = chk;
    e.val = exp;
    exp_bus.push_back(e);
  endtask

  task automatic bus_op(input logic addr, input logic we, input logic [7:0] wdata,
                        input bit chk, input logic [7:0] exp);
    @(negedge clk);
    bus_drive(addr, we, wdata, chk, exp);
  endtask

  task automatic bus_end();
    @(negedge clk);
    bus_req = 1'b0;
    bus_we  = 1'b0;
  endtask

  task automatic wr_data(input logic [7:0] b, input bit expect_sent);
    bus_op(A_DATA, 1'b1, b, 1'b0, 8'h00);
    if (expect_sent) exp_tx.push_back({1'b0, b});
    bus_end();
  endtask

  task automatic rd_status(input logic [7:0] exp);
    bus_op(A_STAT, 1'b0, 8'h00, 1'b1, exp);
    bus_end();
  endtask

  task automatic rd_data(input logic [7:0] exp);
    bus_op(A_DATA, 1'b0, 8'h00, 1'b1, exp);
    bus_end();
  endtask

  // ---------------- receiver model ----------------
  task automatic rx_start(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
  endtask

  task automatic rx_finish();
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rx_clear === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rx_clear_seen", seen, 1'b1);
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic rx_deliver(input logic [7:0] b);
    @(negedge clk);
    rx_start(b);
    rx_finish();
  endtask

  task automatic tx_drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_tx.size() == 0 && tx_busy == 1'b0) break;
    end
    check("tx_drain_left", exp_tx.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  // ---------------- bus monitor / scoreboard ----------------
  initial begin
    logic     req_s;
    bus_exp_t e;
    forever begin
      @(posedge clk);
      req_s = bus_req & rst_n;
      #1;
      if (req_s || bus_ack === 1'b1) check("bus_ack", bus_ack, req_s);
      if (bus_ack === 1'b1 && exp_bus.size() > 0) begin
        e = exp_bus.pop_front();
        if (e.chk) check("bus_rdata", bus_rdata, e.val);
      end else if (bus_ack === 1'b0 && bus_rdata !== 8'h00) begin
        check("rdata_idle", bus_rdata, 8'h00);
      end
    end
  end

  // ---------------- pulse counters ----------------
  initial forever begin
    @(posedge clk); #1;
    if (tx_start === 1'b1) n_start++;
    if (rx_clear === 1'b1) n_clr++;
  end

  // ---------------- transmitter model ----------------
  initial begin
    logic [7:0] b;
    logic [8:0] e;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_start === 1'b1) begin
        b = tx_data;
        e = (exp_tx.size() > 0) ? exp_tx.pop_front() : 9'h1FF;
        check("tx_byte", b, e);
        tx_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("tx_data_hold", tx_data, b);
        while (hold_busy) begin
          @(posedge clk); #1;
        end
        tx_busy = 1'b0;
      end else begin
        tx_busy = busy_force;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main stimulus ----------------
  initial begin
    int s0;
    int c0;
    rst_n = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = 1'b0;
    bus_wdata = 8'h00; rx_ready = 1'b0; rx_data = 8'h00;

    // Reset state, with a request ignored during reset.
    repeat (2) @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = A_DATA; bus_wdata = 8'hAA;
    @(negedge clk);
    bus_req = 1'b0; bus_we = 1'b0;
    @(negedge clk);
    check("rst_ack", bus_ack, 1'b0);
    check("rst_rdata", bus_rdata, 8'h00);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_rx_clear", rx_clear, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_no_start", n_start, 0);
    rd_status(8'h60);

    // Three back-to-back writes are serialized in order.
    s0 = n_start;
    bus_op(A_DATA, 1'b1, 8'h41, 1'b0, 8'h00); exp_tx.push_back(9'h041);
    bus_op(A_DATA, 1'b1, 8'h42, 1'b0, 8'h00); exp_tx.push_back(9'h042);
    bus_op(A_DATA, 1'b1, 8'h43, 1'b0, 8'h00); exp_tx.push_back(9'h043);
    bus_end();
    tx_drain();
    check("b2b_starts", n_start - s0, 3);
    rd_status(8'h60);

    // Nine writes with transmitter busy: eight kept, ninth dropped.
    busy_force = 1'b1;
    repeat (3) @(negedge clk);
    s0 = n_start;
    for (int i = 0; i < 9; i++) begin
      bus_op(A_DATA, 1'b1, 8'hA0 + 8'(i), 1'b0, 8'h00);
      if (i < 8) exp_tx.push_back({1'b0, 8'hA0 + 8'(i)});
    end
    bus_end();
    rd_status(8'h04);
    rd_status(8'h00);
    busy_force = 1'b0;
    tx_drain();
    check("ovf_starts", n_start - s0, 8);
    rd_status(8'h60);

    // Single received byte.
    c0 = n_clr;
    rx_deliver(8'h55);
    repeat (3) @(negedge clk);
    check("rx_one_clear", n_clr - c0, 1);
    rd_status(8'h61);
    rd_data(8'h55);
    rd_data(8'h00);
    rd_status(8'h60);

    // Nine received bytes; the ninth overflows while status is read.
    c0 = n_clr;
    for (int i = 0; i < 8; i++) rx_deliver(8'h10 + 8'(i));
    rd_status(8'h61);
    @(negedge clk);
    rx_start(8'h18);
    bus_drive(A_STAT, 1'b0, 8'h00, 1'b1, 8'h61);
    @(negedge clk);
    bus_req = 1'b0;
    rx_finish();
    check("rx_nine_clears", n_clr - c0, 9);
    rd_status(8'h63);
    rd_status(8'h61);
    for (int i = 0; i < 8; i++) rd_data(8'h10 + 8'(i));
    rd_data(8'h00);
    rd_status(8'h60);

    // Full RX FIFO: a same-cycle pop makes room for the push.
    for (int i = 0; i < 8; i++) rx_deliver(8'h20 + 8'(i));
    @(negedge clk);
    rx_start(8'h28);
    bus_drive(A_DATA, 1'b0, 8'h00, 1'b1, 8'h20);
    @(negedge clk);
    bus_req = 1'b0;
    rx_finish();
    rd_status(8'h61);
    for (int i = 1; i < 9; i++) rd_data(8'h20 + 8'(i));
    rd_data(8'h00);

    // Empty RX FIFO: a same-cycle push is not popped.
    @(negedge clk);
    rx_start(8'h30);
    bus_drive(A_DATA, 1'b0, 8'h00, 1'b1, 8'h00);
    @(negedge clk);
    bus_req = 1'b0;
    rx_finish();
    rd_data(8'h30);
    rd_data(8'h00);
    rd_status(8'h60);

    // Reset during a frame with three bytes queued.
    hold_busy = 1'b1;
    s0 = n_start;
    wr_data(8'h7E, 1'b1);
    wr_data(8'h01, 1'b0);
    wr_data(8'h02, 1'b0);
    wr_data(8'h03, 1'b0);
    repeat (10) @(negedge clk);
    check("frame_started", n_start - s0, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_tx_data", tx_data, 8'h00);
    check("mid_rst_tx_start", tx_start, 1'b0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    rd_status(8'h20);
    check("no_start_while_busy", n_start - s0, 1);
    hold_busy = 1'b0;
    repeat (20) @(negedge clk);
    check("no_stale_bytes", n_start - s0, 1);
    rd_status(8'h60);
    wr_data(8'h99, 1'b1);
    tx_drain();
    check("post_rst_starts", n_start - s0, 2);

    repeat (4) @(negedge clk);
    check("bus_queue_left", exp_bus.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
